dma: RTL and testbench
======================

# dma

Direct-memory-access engine sitting beside `cpu` on the shared RAM bus. It moves received serial bytes from the RS232 receiver FIFO into RAM, and streams a fixed RAM region out to the RS232 transmitter when the CPU requests it. It arbitrates for the RAM bus with `cpu` through the `DMA_Req`/`DMA_Ack`/`DMA_Tx_Start`/`DMA_Ready` handshake, and owns the RAM bus only while granted.

## Interface
Parameters:
- `RX_BASE`, 8'h00: RAM address of the first received byte.
- `RX_LEN`, 3: bytes per received frame, legal range 1..8.
- `TX_BASE`, 8'h04: RAM address of the first byte to transmit.
- `TX_LEN`, 2: bytes per transmission, legal range 1..8.

Ports (one clock; reset is asynchronous and active-high):
- `Clk` in 1: system clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `RX_Data` in 8: head of receiver FIFO (show-ahead), valid while `RX_Empty`=0.
- `RX_Empty` in 1: receiver FIFO empty.
- `RX_Read` out 1: one-cycle pop strobe to the FIFO.
- `TX_Data` out 8: byte to the transmitter.
- `TX_Valid` out 1: one-cycle start strobe to the transmitter.
- `TX_Ready` in 1: transmitter idle.
- `DMA_Req` out 1: bus request to `cpu`.
- `DMA_Ack` in 1: bus grant from `cpu`.
- `DMA_Tx_Start` in 1: level from `cpu` requesting a transmission; `cpu` holds `DMA_Ack`=1 with it.
- `DMA_Ready` out 1: transmission complete.
- `RAM_Addr` out 8, `RAM_Cs` out 1, `RAM_Wen` out 1, `RAM_Oen` out 1: RAM control, all strobes active-high.
- `DataOut` out 8: write data to RAM.
- `DataIn` in 8: RAM read data, valid one cycle after the read strobe.

## Operation
- All outputs are registered (Moore).
- Every RAM output is driven 0 whenever the block does not own the bus.
- State is one of IDLE, RX_REQ, RX_WR, RX_FLAG, TX_RD, TX_LATCH, TX_WAIT, TX_SEND, TX_END.
- Reset: state IDLE; `rx_idx` and `tx_idx` are 0; every output is 0.
- IDLE:
  - `DMA_Tx_Start`=1 → TX_RD. TX has priority over a pending RX.
  - Otherwise `RX_Empty`=0 → RX_REQ.
- RX_REQ: `DMA_Req`=1. Waits for `DMA_Ack`=1, then → RX_WR.
- RX_WR: `DMA_Req`=1, `RAM_Cs`=1, `RAM_Wen`=1, `RAM_Addr`=`RX_BASE`+`rx_idx`, `DataOut`=`RX_Data`, `RX_Read`=1.
  - `rx_idx` increments and wraps to 0 after `RX_LEN`-1.
  - On wrap → RX_FLAG (when configured) or IDLE; otherwise → IDLE.
  - Returning to IDLE drops `DMA_Req` for at least one cycle per byte.
- RX_FLAG: `DMA_Req`=1, RAM write of 8'hFF to `RX_BASE`+`RX_LEN`, then → IDLE.
- TX_RD: `RAM_Cs`=1, `RAM_Oen`=1, `RAM_Addr`=`TX_BASE`+`tx_idx`.
- TX_LATCH: captures `DataIn` into `TX_Data`.
- TX_WAIT: holds until `TX_Ready`=1.
- TX_SEND: `TX_Valid`=1 for one cycle.
  - `tx_idx` increments.
  - Last byte → TX_END; otherwise → TX_RD.
- TX_END: `DMA_Ready`=1 and `tx_idx` cleared. Holds until `DMA_Tx_Start`=0, then → IDLE.
- Bus ownership: `cpu` keeps `DMA_Ack` asserted while `DMA_Req` or `DMA_Tx_Start` is high. Once granted, `DMA_Ack` is not re-sampled.
- `rx_idx` persists across IDLE. A partial frame continues with the next byte.

## Timing
- RX, `DMA_Ack` already high:
  - Edge k samples `RX_Empty`=0.
  - `DMA_Req` is high in cycle k+1.
  - Write strobe and `RX_Read` are high in cycle k+2.
  - Per-byte throughput is one byte per 3 cycles.
- RX, delayed grant: each extra cycle of `DMA_Ack`=0 adds one cycle in RX_REQ.
- TX, per byte: TX_RD 1 cycle, TX_LATCH 1 cycle, TX_WAIT ≥1 cycle, TX_SEND 1 cycle. `TX_Valid` rises at the earliest 3 cycles after the TX_RD edge.
- `DMA_Ready` rises one cycle after the last `TX_Valid`. It falls on the edge after `DMA_Tx_Start` is sampled low.
- `RX_Empty` rising while in RX_REQ: the block still completes RX_WR. The FIFO must not underflow, so `RX_Empty` may only rise after `RX_Read`.
- `DMA_Tx_Start` asserting during RX_REQ, RX_WR or RX_FLAG is served after return to IDLE.
- Reset mid-operation: immediate return to reset state. Any partial frame index is lost.

## Configuration
- `DMA_RX_FLAG_EN` defined: RX_FLAG state present; 8'hFF is written to `RX_BASE`+`RX_LEN` after each complete frame.
- `DMA_RX_FLAG_EN` undefined: RX_FLAG is removed; a frame wrap goes straight to IDLE and no flag write occurs.

## Test plan
- Reset check: pulse `Rst` with the FIFO non-empty → every output is 0 and stays 0 while `Rst`=1.
- RX frame, flag enabled:
  - Stimulus: push 8'h10, 8'h20, 8'h30; `DMA_Ack` answers each `DMA_Req` after 1 cycle.
  - Required: RAM[0x00..0x02] = 10/20/30; RAM[0x03]=FF; exactly 3 `RX_Read` pulses.
  - With the macro undefined, RAM[0x03] is untouched.
- Delayed grant: push 8'h55 and hold `DMA_Ack`=0 for 5 cycles → `DMA_Req` stays high for 5 cycles with no RAM strobe. The write of 8'h55 to 0x00 occurs 1 cycle after `DMA_Ack` rises.
- TX:
  - Stimulus: preload RAM[0x04]=A5, RAM[0x05]=3C; assert `DMA_Tx_Start` with `DMA_Ack`; hold `TX_Ready`=0 for 10 cycles after the first `TX_Valid`.
  - Required: `TX_Valid` with A5, then, no earlier than `TX_Ready` returning high, `TX_Valid` with 3C.
  - `DMA_Ready`=1 until `DMA_Tx_Start` drops, then 0.
- Simultaneous: `RX_Empty` falls on the same edge `DMA_Tx_Start` rises → both TX bytes complete before any RX write or `DMA_Req`.
- Reset mid-frame: after 2 RX bytes, pulse `Rst`, then push 8'h77 → 8'h77 is written to 0x00, not 0x02.

Source files
------------

// File: rtl/dma.sv
// dma: moves received serial bytes from the RX FIFO into RAM and streams a
// fixed RAM region to the serial transmitter on request from the cpu.
// Optional feature macro: DMA_RX_FLAG_EN -- when defined, 8'hFF is written
// to RX_BASE+RX_LEN after every complete received frame.
module dma #(
    parameter logic [7:0] RX_BASE = 8'h00,
    parameter int         RX_LEN  = 3,
    parameter logic [7:0] TX_BASE = 8'h04,
    parameter int         TX_LEN  = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] RX_Data,
    input  logic       RX_Empty,
    output logic       RX_Read,
    output logic [7:0] TX_Data,
    output logic       TX_Valid,
    input  logic       TX_Ready,
    output logic       DMA_Req,
    input  logic       DMA_Ack,
    input  logic       DMA_Tx_Start,
    output logic       DMA_Ready,
    output logic [7:0] RAM_Addr,
    output logic       RAM_Cs,
    output logic       RAM_Wen,
    output logic       RAM_Oen,
    output logic [7:0] DataOut,
    input  logic [7:0] DataIn
);

    localparam logic [3:0] RX_LAST = 4'(RX_LEN - 1);
    localparam logic [3:0] TX_LAST = 4'(TX_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        RX_REQ,
        RX_WR,
`ifdef DMA_RX_FLAG_EN
        RX_FLAG,
`endif
        TX_RD,
        TX_LATCH,
        TX_WAIT,
        TX_SEND,
        TX_END
    } state_t;

    state_t     state, state_nx;
    logic [3:0] rx_idx, rx_idx_nx;
    logic [3:0] tx_idx, tx_idx_nx;

    // State and byte indices; a reset drops any partial frame position.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            rx_idx <= '0;
            tx_idx <= '0;
        end else begin
            state  <= state_nx;
            rx_idx <= rx_idx_nx;
            tx_idx <= tx_idx_nx;
        end
    end

    // Next-state and index update; TX wins over a pending RX byte in IDLE.
    always_comb begin
        state_nx  = state;
        rx_idx_nx = rx_idx;
        tx_idx_nx = tx_idx;
        case (state)
            IDLE: begin
                if (DMA_Tx_Start)   state_nx = TX_RD;
                else if (!RX_Empty) state_nx = RX_REQ;
            end
            RX_REQ: if (DMA_Ack) state_nx = RX_WR;
            RX_WR: begin
                // Always leave the bus after a byte so the cpu gets a gap.
                if (rx_idx == RX_LAST) begin
                    rx_idx_nx = '0;
`ifdef DMA_RX_FLAG_EN
                    state_nx  = RX_FLAG;
`else
                    state_nx  = IDLE;
`endif
                end else begin
                    rx_idx_nx = rx_idx + 4'd1;
                    state_nx  = IDLE;
                end
            end
`ifdef DMA_RX_FLAG_EN
            RX_FLAG: state_nx = IDLE;
`endif
            TX_RD:    state_nx = TX_LATCH;
            TX_LATCH: state_nx = TX_WAIT;
            TX_WAIT:  if (TX_Ready) state_nx = TX_SEND;
            TX_SEND: begin
                tx_idx_nx = tx_idx + 4'd1;
                state_nx  = (tx_idx == TX_LAST) ? TX_END : TX_RD;
            end
            TX_END: begin
                tx_idx_nx = '0;
                if (!DMA_Tx_Start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs registered from the next state so they line up with the
    // state they belong to; RAM outputs stay 0 unless we own the bus.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            RX_Read   <= 1'b0;
            TX_Valid  <= 1'b0;
            DMA_Req   <= 1'b0;
            DMA_Ready <= 1'b0;
            RAM_Addr  <= '0;
            RAM_Cs    <= 1'b0;
            RAM_Wen   <= 1'b0;
            RAM_Oen   <= 1'b0;
            DataOut   <= '0;
        end else begin
            RX_Read   <= 1'b0;
            TX_Valid  <= 1'b0;
            DMA_Req   <= 1'b0;
            DMA_Ready <= 1'b0;
            RAM_Addr  <= '0;
            RAM_Cs    <= 1'b0;
            RAM_Wen   <= 1'b0;
            RAM_Oen   <= 1'b0;
            DataOut   <= '0;
            case (state_nx)
                RX_REQ: DMA_Req <= 1'b1;
                RX_WR: begin
                    DMA_Req  <= 1'b1;
                    RAM_Cs   <= 1'b1;
                    RAM_Wen  <= 1'b1;
                    RAM_Addr <= RX_BASE + {4'b0, rx_idx_nx};
                    DataOut  <= RX_Data;
                    RX_Read  <= 1'b1;
                end
`ifdef DMA_RX_FLAG_EN
                RX_FLAG: begin
                    DMA_Req  <= 1'b1;
                    RAM_Cs   <= 1'b1;
                    RAM_Wen  <= 1'b1;
                    RAM_Addr <= RX_BASE + 8'(RX_LEN);
                    DataOut  <= 8'hFF;
                end
`endif
                TX_RD: begin
                    RAM_Cs   <= 1'b1;
                    RAM_Oen  <= 1'b1;
                    RAM_Addr <= TX_BASE + {4'b0, tx_idx_nx};
                end
                TX_SEND: TX_Valid  <= 1'b1;
                TX_END:  DMA_Ready <= 1'b1;
                default: ;
            endcase
        end
    end

    // RAM read data arrives the cycle after the strobe, i.e. during TX_LATCH.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                  TX_Data <= '0;
        else if (state == TX_LATCH) TX_Data <= DataIn;
    end

endmodule

// File: tb/tb_dma.sv
// tb_dma: directed scoreboard bench for dma with RAM, FIFO and cpu-grant models.
module tb_dma;

    localparam logic [7:0] FLAG_ADDR = 8'h03;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] RX_Data;
    logic       RX_Empty;
    logic       RX_Read;
    logic [7:0] TX_Data;
    logic       TX_Valid;
    logic       TX_Ready;
    logic       DMA_Req;
    logic       DMA_Ack;
    logic       DMA_Tx_Start;
    logic       DMA_Ready;
    logic [7:0] RAM_Addr;
    logic       RAM_Cs;
    logic       RAM_Wen;
    logic       RAM_Oen;
    logic [7:0] DataOut;
    logic [7:0] DataIn;

    dma dut (
        .Clk(Clk), .Rst(Rst),
        .RX_Data(RX_Data), .RX_Empty(RX_Empty), .RX_Read(RX_Read),
        .TX_Data(TX_Data), .TX_Valid(TX_Valid), .TX_Ready(TX_Ready),
        .DMA_Req(DMA_Req), .DMA_Ack(DMA_Ack), .DMA_Tx_Start(DMA_Tx_Start),
        .DMA_Ready(DMA_Ready),
        .RAM_Addr(RAM_Addr), .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
        .DataOut(DataOut), .DataIn(DataIn)
    );

    initial forever #5 Clk = ~Clk;

    logic [33:0] outs;
    assign outs = {RX_Read, TX_Valid, DMA_Req, DMA_Ready, RAM_Cs, RAM_Wen, RAM_Oen,
                   RAM_Addr, DataOut, TX_Data};

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rd_cnt = 0;
    int         viol = 0;
    int         model_idx = 0;
    int         tx_cyc = 0;
    logic [7:0] ram [256];
    logic [7:0] fifo [$];
    logic [15:0] exp_wr [$];
    logic [15:0] obs_wr [$];
    logic [7:0] exp_tx [$];
    logic [7:0] obs_tx [$];
    logic       tx_start = 1'b0;
    logic       ack_block = 1'b0;
    logic       req_q = 1'b0;
    logic       rd_pend = 1'b0;
    logic [7:0] rd_data = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic upd_in();
        RX_Empty     = (fifo.size() == 0);
        RX_Data      = RX_Empty ? 8'h00 : fifo[0];
        DMA_Tx_Start = tx_start;
    endtask

    // One clock: observe this cycle's outputs at the falling edge and let the
    // RAM, FIFO and cpu-grant models react before the next rising edge.
    task automatic step();
        @(negedge Clk);
        cyc++;
        if (rd_pend) begin
            DataIn  = rd_data;
            rd_pend = 1'b0;
        end
        if (!Rst) begin
            if (RAM_Cs && RAM_Wen) begin
                ram[RAM_Addr] = DataOut;
                obs_wr.push_back({RAM_Addr, DataOut});
                if (!DMA_Req) viol++;
            end
            if (RAM_Cs && RAM_Oen) begin
                rd_data = ram[RAM_Addr];
                rd_pend = 1'b1;
                if (!tx_start) viol++;
            end
            if (RX_Read) begin
                rd_cnt++;
                if (fifo.size() == 0) viol++;
                else void'(fifo.pop_front());
            end
            if (TX_Valid) begin
                obs_tx.push_back(TX_Data);
                tx_cyc = cyc;
            end
        end
        // cpu grants one cycle after seeing a request; TX start carries its own grant
        DMA_Ack = tx_start | (req_q & ~ack_block);
        req_q   = DMA_Req;
        upd_in();
    endtask

    task automatic push_rx(input logic [7:0] b);
        fifo.push_back(b);
        exp_wr.push_back({8'(model_idx), b});
        if (model_idx == 2) begin
            model_idx = 0;
`ifdef DMA_RX_FLAG_EN
            exp_wr.push_back({FLAG_ADDR, 8'hFF});
`endif
        end else begin
            model_idx++;
        end
    endtask

    task automatic drain_wr(input string tag);
        for (int i = 0; i < 80 && obs_wr.size() < exp_wr.size(); i++) step();
        repeat (8) step();
        chk($sformatf("%s_wr_count", tag), obs_wr.size(), exp_wr.size());
        for (int i = 0; exp_wr.size() > 0 && obs_wr.size() > 0; i++)
            chk($sformatf("%s_wr%0d", tag, i), obs_wr.pop_front(), exp_wr.pop_front());
        exp_wr.delete();
        obs_wr.delete();
    endtask

    task automatic drain_tx(input string tag);
        chk($sformatf("%s_tx_count", tag), obs_tx.size(), exp_tx.size());
        for (int i = 0; exp_tx.size() > 0 && obs_tx.size() > 0; i++)
            chk($sformatf("%s_tx%0d", tag, i), obs_tx.pop_front(), exp_tx.pop_front());
        exp_tx.delete();
        obs_tx.delete();
    endtask

    task automatic pulse_reset(input string tag);
        Rst = 1'b1;
        #1;
        chk({tag, "_async"}, outs, 0);
        fifo.delete();
        exp_wr.delete();
        obs_wr.delete();
        model_idx = 0;
        req_q     = 1'b0;
        rd_pend   = 1'b0;
        tx_start  = 1'b0;
        DMA_Ack   = 1'b0;
        upd_in();
        step();
        Rst = 1'b0;
        step();
    endtask

    initial begin
        int s, r, bad, early;
        for (int i = 0; i < 256; i++) ram[i] = 8'hEE;
        Rst      = 1'b1;
        DataIn   = 8'h00;
        TX_Ready = 1'b1;
        DMA_Ack  = 1'b0;
        fifo.push_back(8'h99);
        upd_in();

        // reset with a non-empty FIFO: everything quiet while Rst is held
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_outs%0d", i), outs, 0);
        end
        fifo.delete();
        upd_in();
        Rst = 1'b0;
        step();
        step();
        chk("idle_outs", outs, 0);

        // RX frame 10/20/30
        rd_cnt = 0;
        push_rx(8'h10);
        push_rx(8'h20);
        push_rx(8'h30);
        upd_in();
        step();
        chk("rx_req_k1", {DMA_Req, RAM_Cs, RX_Read}, 3'b100);
        step();
        chk("rx_wait_ack", {DMA_Req, RAM_Cs, RX_Read}, 3'b100);
        step();
        chk("rx_wr_k2", {RAM_Cs, RAM_Wen, RX_Read, RAM_Addr, DataOut}, {3'b111, 8'h00, 8'h10});
        drain_wr("rx");
        chk("rx_reads", rd_cnt, 3);
        chk("rx_ram2", ram[2], 8'h30);
`ifdef DMA_RX_FLAG_EN
        chk("rx_flag", ram[FLAG_ADDR], 8'hFF);
`else
        chk("rx_noflag", ram[FLAG_ADDR], 8'hEE);
`endif

        // delayed grant: request held 5 cycles without any RAM strobe
        ack_block = 1'b1;
        push_rx(8'h55);
        upd_in();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!DMA_Req || RAM_Cs || RAM_Wen) bad++;
        end
        chk("grant_hold", bad, 0);
        ack_block = 1'b0;
        step();
        chk("grant_ack_cyc", {DMA_Ack, DMA_Req, RAM_Cs}, 3'b110);
        step();
        chk("grant_wr", {RAM_Wen, RAM_Addr, DataOut}, {1'b1, 8'h00, 8'h55});
        drain_wr("grant");

        // TX of A5, 3C with the transmitter busy after the first byte
        ram[4] = 8'hA5;
        ram[5] = 8'h3C;
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h3C);
        tx_start = 1'b1;
        DMA_Ack  = 1'b1;
        upd_in();
        s = cyc;
        for (int i = 0; i < 20 && obs_tx.size() < 1; i++) step();
        chk("tx_first_lat", tx_cyc - s, 4);
        TX_Ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("tx_busy_hold", obs_tx.size(), 1);
        TX_Ready = 1'b1;
        r = cyc;
        for (int i = 0; i < 20 && obs_tx.size() < 2; i++) step();
        chk("tx_second_after_ready", tx_cyc - r, 1);
        step();
        chk("tx_ready_rise", DMA_Ready, 1);
        repeat (3) step();
        chk("tx_ready_hold", DMA_Ready, 1);
        tx_start = 1'b0;
        upd_in();
        step();
        chk("tx_ready_fall", DMA_Ready, 0);
        drain_tx("tx");

        // RX byte and TX start arrive together: TX finishes first
        ram[4] = 8'h11;
        ram[5] = 8'h22;
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        push_rx(8'h66);
        tx_start = 1'b1;
        DMA_Ack  = 1'b1;
        upd_in();
        early = 0;
        for (int i = 0; i < 40 && !DMA_Ready; i++) begin
            step();
            if (DMA_Req || RAM_Wen) early++;
        end
        chk("simul_tx_first", early, 0);
        chk("simul_ready", DMA_Ready, 1);
        drain_tx("simul");
        tx_start = 1'b0;
        upd_in();
        drain_wr("simul");

        // reset mid-frame: frame position restarts at RX_BASE
        pulse_reset("rst1");
        push_rx(8'h33);
        push_rx(8'h44);
        upd_in();
        drain_wr("mf");
        pulse_reset("rst2");
        push_rx(8'h77);
        upd_in();
        drain_wr("mf_rst");
        chk("mf_ram0", ram[0], 8'h77);

        chk("bus_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
